avalon_port_arbiter: RTL and testbench

Parametrised successor to the single-CPU bus controller. It connects NUM_PORTS independent stall-based requesters (instruction fetch, data load/store, debug/DMA) to one Avalon-MM master port. It arbitrates with fixed or round-robin priority and performs byte-lane alignment for byte, half and word stores. It also performs lane extraction with sign or zero extension for loads, and flags misaligned or illegal requests without issuing a bus cycle.

---
 rtl/avalon_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_avalon_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_port_arbiter.sv
// Multi-port arbiter onto a single Avalon-MM master with byte-lane alignment
// for stores and lane extraction with sign/zero extension for loads.
module avalon_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int RR_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PORTS-1:0]     port_read,
  input  logic [NUM_PORTS-1:0]     port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_address,
  input  logic [NUM_PORTS*32-1:0]  port_writedata,
  input  logic [NUM_PORTS*2-1:0]   port_size,
  input  logic [NUM_PORTS-1:0]     port_signed,
  output logic [NUM_PORTS*32-1:0]  port_readdata,
  output logic [NUM_PORTS-1:0]     port_done,
  output logic [NUM_PORTS-1:0]     port_err,
  output logic [NUM_PORTS-1:0]     port_stall,
  output logic [ADDR_W-1:0]        av_address,
  output logic                     av_read,
  output logic                     av_write,
  output logic [31:0]              av_writedata,
  output logic [3:0]               av_byteenable,
  input  logic                     av_waitrequest,
  input  logic [31:0]              av_readdata
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [1:0]      size_q;
  logic [1:0]      off_q;
  logic            signed_q;
  logic            write_q;

  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0]   pick;
  logic            any_req;

  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]     sel_data;
  logic [1:0]      sel_size;
  logic [1:0]      sel_off;
  logic            sel_rd;
  logic            sel_wr;
  logic            sel_signed;
  logic            sel_bad;
  logic [3:0]      sel_be;
  logic [31:0]     sel_wdata;

  logic [31:0]     lane;
  logic [31:0]     ext;

  assign req        = port_read | port_write;
  assign port_stall = req & ~port_done;

  // Round-robin searches upward from the port after the last grant.
  always_comb begin
    logic [GW-1:0] cand;
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (RR_MODE != 0)
        cand = GW'((int'(last_grant) + 1 + i) % NUM_PORTS);
      else
        cand = GW'(i);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign sel_addr   = port_address[int'(pick)*ADDR_W +: ADDR_W];
  assign sel_data   = port_writedata[int'(pick)*32 +: 32];
  assign sel_size   = port_size[int'(pick)*2 +: 2];
  assign sel_rd     = port_read[pick];
  assign sel_wr     = port_write[pick];
  assign sel_signed = port_signed[pick];
  assign sel_off    = sel_addr[1:0];

  assign sel_bad = (sel_rd && sel_wr) || (sel_size == 2'b11) ||
                   (sel_size == 2'b01 && sel_off[0]) ||
                   (sel_size == 2'b00 && sel_off != 2'b00);

  // Store lanes are little-endian: byte offset k lands in lane k.
  always_comb begin
    sel_be    = 4'b1111;
    sel_wdata = sel_data;
    if (sel_wr) begin
      case (sel_size)
        2'b01: begin
          sel_be    = sel_off[1] ? 4'b1100 : 4'b0011;
          sel_wdata = sel_data << {sel_off[1], 4'b0000};
        end
        2'b10: begin
          sel_be    = 4'b0001 << sel_off;
          sel_wdata = sel_data << {sel_off, 3'b000};
        end
        default: begin
          sel_be    = 4'b1111;
          sel_wdata = sel_data;
        end
      endcase
    end
  end

  always_comb begin
    lane = av_readdata >> {off_q, 3'b000};
    case (size_q)
      2'b01:   ext = {{16{signed_q & lane[15]}}, lane[15:0]};
      2'b10:   ext = {{24{signed_q & lane[7]}}, lane[7:0]};
      default: ext = av_readdata;
    endcase
  end

  // Rejected requests skip the bus and report done+err one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= GW'(NUM_PORTS - 1);
      size_q        <= '0;
      off_q         <= '0;
      signed_q      <= 1'b0;
      write_q       <= 1'b0;
      port_readdata <= '0;
      port_done     <= '0;
      port_err      <= '0;
      av_address    <= '0;
      av_read       <= 1'b0;
      av_write      <= 1'b0;
      av_writedata  <= '0;
      av_byteenable <= '0;
    end else begin
      port_done <= '0;
      port_err  <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            size_q     <= sel_size;
            off_q      <= sel_off;
            signed_q   <= sel_signed;
            write_q    <= sel_wr;
            if (sel_bad) begin
              state           <= DONE;
              port_done[pick] <= 1'b1;
              port_err[pick]  <= 1'b1;
            end else begin
              state         <= BUS;
              av_address    <= {sel_addr[ADDR_W-1:2], 2'b00};
              av_read       <= sel_rd;
              av_write      <= sel_wr;
              av_byteenable <= sel_be;
              if (sel_wr)
                av_writedata <= sel_wdata;
            end
          end
        end
        BUS: begin
          if (!av_waitrequest) begin
            state            <= DONE;
            av_read          <= 1'b0;
            av_write         <= 1'b0;
            av_byteenable    <= '0;
            port_done[grant] <= 1'b1;
            if (!write_q)
              port_readdata[int'(grant)*32 +: 32] <= ext;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_port_arbiter.sv
// Bench for avalon_port_arbiter: a fixed-priority and a round-robin instance
// share the same stimulus; single-port vectors come from a table.
module tb_avalon_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  port_read, port_write, port_signed;
  logic [63:0] port_address, port_writedata;
  logic [3:0]  port_size;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  logic [63:0] port_readdata_f, port_readdata_r;
  logic [1:0]  port_done_f, port_err_f, port_stall_f;
  logic [1:0]  port_done_r, port_err_r, port_stall_r;
  logic [31:0] av_address_f, av_writedata_f, av_address_r, av_writedata_r;
  logic        av_read_f, av_write_f, av_read_r, av_write_r;
  logic [3:0]  av_byteenable_f, av_byteenable_r;

  avalon_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .RR_MODE(0)) dut_fixed (
    .clk(clk), .reset(reset),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_writedata(port_writedata),
    .port_size(port_size), .port_signed(port_signed),
    .port_readdata(port_readdata_f), .port_done(port_done_f),
    .port_err(port_err_f), .port_stall(port_stall_f),
    .av_address(av_address_f), .av_read(av_read_f), .av_write(av_write_f),
    .av_writedata(av_writedata_f), .av_byteenable(av_byteenable_f),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata)
  );

  avalon_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_writedata(port_writedata),
    .port_size(port_size), .port_signed(port_signed),
    .port_readdata(port_readdata_r), .port_done(port_done_r),
    .port_err(port_err_r), .port_stall(port_stall_r),
    .av_address(av_address_r), .av_read(av_read_r), .av_write(av_write_r),
    .av_writedata(av_writedata_r), .av_byteenable(av_byteenable_r),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata)
  );

  typedef struct {
    int          port;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic        err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[14];
  vec_t sb_q[$];
  int   grant_q_f[$];
  int   grant_q_r[$];

  function automatic vec_t mk(int port, logic rd, logic wr, logic [31:0] addr,
                              logic [1:0] size, logic sgn, logic [31:0] wdata,
                              logic [31:0] rdata, int nwait, logic err,
                              logic [31:0] exp_addr, logic [3:0] exp_be,
                              logic [31:0] exp_wdata, logic [31:0] exp_rdata);
    vec_t v;
    v.port = port; v.rd = rd; v.wr = wr; v.addr = addr; v.size = size;
    v.sgn = sgn; v.wdata = wdata; v.rdata = rdata; v.nwait = nwait;
    v.err = err; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    port_read = '0; port_write = '0; port_signed = '0;
    port_address = '0; port_writedata = '0; port_size = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    clearInputs();
    port_read[v.port]             = v.rd;
    port_write[v.port]            = v.wr;
    port_signed[v.port]           = v.sgn;
    port_address[v.port*32 +: 32] = v.addr;
    port_writedata[v.port*32 +: 32] = v.wdata;
    port_size[v.port*2 +: 2]      = v.size;
    av_readdata    = v.rdata;
    av_waitrequest = 1'b0;
    sb_q.push_back(v);
  endtask

  // Watches one transaction from its IDLE cycle (cycle 0) to its done pulse.
  task automatic awaitCompletion(input int idx);
    vec_t h, e;
    int   p, bus_cycles, done_cycle;
    logic done_seen;
    h = sb_q[0];
    p = h.port;
    bus_cycles = 0; done_cycle = -1; done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      if (av_read_f || av_write_f) begin
        bus_cycles++;
        checkOutput($sformatf("v%0d.av_read", idx), 32'(av_read_f), 32'(h.rd));
        checkOutput($sformatf("v%0d.av_write", idx), 32'(av_write_f), 32'(h.wr));
        checkOutput($sformatf("v%0d.av_address", idx), av_address_f, h.exp_addr);
        checkOutput($sformatf("v%0d.av_byteenable", idx), 32'(av_byteenable_f), 32'(h.exp_be));
        if (h.wr)
          checkOutput($sformatf("v%0d.av_writedata", idx), av_writedata_f, h.exp_wdata);
      end
      if (port_done_f[p]) begin
        done_seen  = 1'b1;
        done_cycle = c;
        e = sb_q.pop_front();
        checkOutput($sformatf("v%0d.done_vec", idx), 32'(port_done_f), 32'(2'b01 << p));
        checkOutput($sformatf("v%0d.err", idx), 32'(port_err_f[p]), 32'(e.err));
        checkOutput($sformatf("v%0d.stall_done", idx), 32'(port_stall_f[p]), 32'd0);
        checkOutput($sformatf("v%0d.rr_done", idx), 32'(port_done_r[p]), 32'd1);
        if (e.rd && !e.err) begin
          checkOutput($sformatf("v%0d.readdata", idx), port_readdata_f[p*32 +: 32], e.exp_rdata);
          checkOutput($sformatf("v%0d.rr_readdata", idx), port_readdata_r[p*32 +: 32], e.exp_rdata);
        end
        port_read = '0;
        port_write = '0;
      end else begin
        checkOutput($sformatf("v%0d.stall", idx), 32'(port_stall_f[p]), 32'd1);
        av_waitrequest = (c >= 1 && c <= h.nwait);
      end
    end
    if (!done_seen) begin
      checks++; failures++;
      $display("[TB] FAIL v%0d.timeout actual=no_done required=done", idx);
      void'(sb_q.pop_front());
      clearInputs();
    end else begin
      checkOutput($sformatf("v%0d.latency", idx), 32'(done_cycle),
                  h.err ? 32'd1 : 32'(2 + h.nwait));
      checkOutput($sformatf("v%0d.bus_cycles", idx), 32'(bus_cycles),
                  h.err ? 32'd0 : 32'(1 + h.nwait));
    end
    av_waitrequest = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got_f, got_r, cnt;
    logic seen;

    //            port rd wr addr        size  sgn wdata         rdata         nw err exp_addr      be       exp_wdata     exp_rdata
    vecs[0]  = mk(1, 0, 1, 32'h00001003, 2'b10, 0, 32'h000000AB, 32'h0,        0, 0, 32'h00001000, 4'b1000, 32'hAB000000, 32'h0);
    vecs[1]  = mk(0, 1, 0, 32'h00002002, 2'b01, 1, 32'h0,        32'h80011234, 0, 0, 32'h00002000, 4'b1111, 32'h0,        32'hFFFF8001);
    vecs[2]  = mk(0, 1, 0, 32'h00002002, 2'b01, 0, 32'h0,        32'h80011234, 0, 0, 32'h00002000, 4'b1111, 32'h0,        32'h00008001);
    vecs[3]  = mk(0, 0, 1, 32'h00002000, 2'b01, 0, 32'h0000BEEF, 32'h0,        0, 0, 32'h00002000, 4'b0011, 32'h0000BEEF, 32'h0);
    vecs[4]  = mk(1, 0, 1, 32'h00003004, 2'b00, 0, 32'h12345678, 32'h0,        1, 0, 32'h00003004, 4'b1111, 32'h12345678, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h00005001, 2'b10, 1, 32'h0,        32'h11229344, 0, 0, 32'h00005000, 4'b1111, 32'h0,        32'hFFFFFF93);
    vecs[6]  = mk(1, 1, 0, 32'h00005003, 2'b10, 0, 32'h0,        32'hF0000000, 0, 0, 32'h00005000, 4'b1111, 32'h0,        32'h000000F0);
    vecs[7]  = mk(0, 1, 0, 32'h00004000, 2'b00, 0, 32'h0,        32'hCAFEF00D, 3, 0, 32'h00004000, 4'b1111, 32'h0,        32'hCAFEF00D);
    vecs[8]  = mk(0, 0, 1, 32'h00006000, 2'b10, 0, 32'h0000005A, 32'h0,        0, 0, 32'h00006000, 4'b0001, 32'h0000005A, 32'h0);
    vecs[9]  = mk(1, 0, 1, 32'h00007002, 2'b01, 0, 32'h00001234, 32'h0,        0, 0, 32'h00007000, 4'b1100, 32'h12340000, 32'h0);
    vecs[10] = mk(0, 1, 0, 32'h00003001, 2'b00, 0, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1, 1, 1, 32'h00000100, 2'b00, 0, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(0, 1, 0, 32'h00000000, 2'b11, 0, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(1, 1, 0, 32'h00008001, 2'b01, 0, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);

    reset = 1'b0;
    clearInputs();
    av_waitrequest = 1'b0;
    av_readdata = '0;
    #12;
    checkOutput("reset.readdata_lo", port_readdata_f[31:0], 32'h0);
    checkOutput("reset.readdata_hi", port_readdata_f[63:32], 32'h0);
    checkOutput("reset.done_err", 32'({port_done_f, port_err_f, port_stall_f}), 32'h0);
    checkOutput("reset.strobes", 32'({av_read_f, av_write_f, av_byteenable_f}), 32'h0);
    checkOutput("reset.av_address", av_address_f, 32'h0);
    checkOutput("reset.av_writedata", av_writedata_f, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      awaitCompletion(i);
    end

    // Two ports requesting back to back: fixed always serves 0, RR alternates.
    @(posedge clk); #1;
    clearInputs();
    port_read = 2'b11;
    av_readdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      grant_q_f.push_back(0);
      grant_q_r.push_back(k % 2);
    end
    got_f = 0; got_r = 0;
    for (int c = 0; c < 40 && (got_f < 4 || got_r < 4); c++) begin
      @(negedge clk);
      if (|port_done_f && grant_q_f.size() > 0) begin
        checkOutput($sformatf("arb.fixed%0d", got_f), 32'(onehot_idx(port_done_f)), 32'(grant_q_f.pop_front()));
        got_f++;
      end
      if (|port_done_r && grant_q_r.size() > 0) begin
        checkOutput($sformatf("arb.rr%0d", got_r), 32'(onehot_idx(port_done_r)), 32'(grant_q_r.pop_front()));
        got_r++;
      end
    end
    clearInputs();
    if (got_f < 4 || got_r < 4) begin
      checks++; failures++;
      $display("[TB] FAIL arb.timeout actual=%0d/%0d required=4/4", got_f, got_r);
    end

    // Reset during a stalled bus cycle abandons the transfer without done.
    @(posedge clk); #1;
    @(posedge clk); #1;
    clearInputs();
    port_read[0] = 1'b1;
    port_address[31:0] = 32'h00000100;
    av_waitrequest = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = av_read_f;
    end
    checkOutput("rst.bus_reached", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst.av_read_f", 32'(av_read_f), 32'd0);
    checkOutput("rst.av_read_r", 32'(av_read_r), 32'd0);
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      cnt += int'(port_done_f[0]) + int'(port_done_r[0]);
    end
    checkOutput("rst.no_done", 32'(cnt), 32'd0);
    reset = 1'b1;
    av_waitrequest = 1'b0;
    av_readdata = 32'h13579BDF;
    cnt = -1;
    for (int c = 1; c <= 10 && cnt < 0; c++) begin
      @(negedge clk);
      if (port_done_f[0]) cnt = c;
    end
    clearInputs();
    checkOutput("rst.restart_latency", 32'(cnt), 32'd2);
    checkOutput("rst.restart_readdata", port_readdata_f[31:0], 32'h13579BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
